// File: rtl/wb_stage.sv
// wb_stage: write-back stage after execute-memory.
// Registers the EX/MEM slot, muxes register-file write data, drives the
// forwarding path and hands OUT-instruction data to an external port.
// Optional feature macro: WB_OUT_FIFO_EN
//   defined   -> OUT data goes through an OUT_FIFO_DEPTH-entry valid/ready buffer,
//                with an upstream stall when that buffer is full
//   undefined -> a single output register; o_port_valid pulses for one cycle per OUT
module wb_stage #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 3,
  parameter int OUT_FIFO_DEPTH = 2,
  parameter int RETIRE_W       = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_flush,
  input  logic [DATA_W-1:0]   i_ex_result,
  input  logic [DATA_W-1:0]   i_memory_data,
  input  logic [DATA_W-1:0]   i_immediate,
  input  logic [DATA_W-1:0]   i_in_port,
  input  logic [1:0]          i_wb_selector,
  input  logic                i_write_back,
  input  logic [ADDR_W-1:0]   i_write_addr,
  input  logic                i_output_port,
  input  logic [DATA_W-1:0]   i_out_data,
  input  logic [ADDR_W-1:0]   i_ex_src1,
  input  logic [ADDR_W-1:0]   i_ex_src2,
  input  logic                i_port_ready,
  output logic                o_rf_write_en,
  output logic [ADDR_W-1:0]   o_rf_write_addr,
  output logic [DATA_W-1:0]   o_rf_write_data,
  output logic [DATA_W-1:0]   o_data_wb,
  output logic                o_data1_forward,
  output logic                o_data2_forward,
  output logic                o_port_valid,
  output logic [DATA_W-1:0]   o_port_data,
  output logic                o_stall_req,
  output logic [RETIRE_W-1:0] o_retired
);

  // Registered EX/MEM slot
  logic                valid_q, valid_d;
  logic                wb_q, wb_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [1:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   ex_q, ex_d;
  logic [DATA_W-1:0]   mem_q, mem_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   inp_q, inp_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic stall;
  logic load_real;   // a real, non-flushed instruction is accepted this edge
  logic push;        // accepted slot is an OUT instruction

  assign load_real = i_valid & ~i_flush & ~stall;
  assign push      = load_real & i_output_port;

  // Next slot: a stalled or flushed slot loads a bubble so nothing writes back twice
  always_comb begin
    valid_d   = load_real;
    wb_d      = load_real & i_write_back;
    waddr_d   = i_write_addr;
    sel_d     = i_wb_selector;
    ex_d      = i_ex_result;
    mem_d     = i_memory_data;
    imm_d     = i_immediate;
    inp_d     = i_in_port;
    retired_d = retired_q;
    if (load_real) retired_d = retired_q + RETIRE_W'(1);
  end

  // Slot registers and retire counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      wb_q      <= 1'b0;
      waddr_q   <= '0;
      sel_q     <= '0;
      ex_q      <= '0;
      mem_q     <= '0;
      imm_q     <= '0;
      inp_q     <= '0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wb_q      <= wb_d;
      waddr_q   <= waddr_d;
      sel_q     <= sel_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      imm_q     <= imm_d;
      inp_q     <= inp_d;
      retired_q <= retired_d;
    end
  end

  // Write-data select from the registered fields
  always_comb begin
    o_rf_write_data = ex_q;
    case (sel_q)
      2'b00:   o_rf_write_data = ex_q;
      2'b01:   o_rf_write_data = mem_q;
      2'b10:   o_rf_write_data = imm_q;
      default: o_rf_write_data = inp_q;
    endcase
  end

  assign o_rf_write_en   = valid_q & wb_q;
  assign o_rf_write_addr = waddr_q;
  assign o_data_wb       = o_rf_write_data;
  assign o_data1_forward = o_rf_write_en & (waddr_q == i_ex_src1);
  assign o_data2_forward = o_rf_write_en & (waddr_q == i_ex_src2);
  assign o_retired       = retired_q;
  assign o_stall_req     = stall;

`ifdef WB_OUT_FIFO_EN
  localparam int PW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);

  logic [OUT_FIFO_DEPTH-1:0][DATA_W-1:0] buf_q, buf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;
  logic          pop;

  assign full         = (cnt_q == CW'(OUT_FIFO_DEPTH));
  assign o_port_valid = (cnt_q != '0);
  assign pop          = o_port_valid & i_port_ready;
  assign o_port_data  = buf_q[rd_ptr_q];
  // A pop in the same cycle frees the slot the push needs, so no stall then
  assign stall        = i_valid & ~i_flush & i_output_port & full & ~pop;

  // Buffer next state: pointers wrap naturally since depth is a power of two
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      buf_d[wr_ptr_q] = i_out_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Output buffer registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      buf_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  logic              port_vld_q, port_vld_d;
  logic [DATA_W-1:0] port_data_q, port_data_d;
  logic              unused_port_ready;

  // No back-pressure path without the buffer
  assign unused_port_ready = i_port_ready;
  assign stall             = 1'b0;
  assign o_port_valid      = port_vld_q;
  assign o_port_data       = port_data_q;

  // Single output register: valid pulses once per OUT, data holds until the next OUT
  always_comb begin
    port_vld_d  = push;
    port_data_d = push ? i_out_data : port_data_q;
  end

  // Output register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      port_vld_q  <= 1'b0;
      port_data_q <= '0;
    end else begin
      port_vld_q  <= port_vld_d;
      port_data_q <= port_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; follows WB_OUT_FIFO_EN the same way the RTL does.
module tb_wb_stage;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid, i_flush;
  logic [15:0] i_ex_result, i_memory_data, i_immediate, i_in_port, i_out_data;
  logic [1:0]  i_wb_selector;
  logic        i_write_back, i_output_port, i_port_ready;
  logic [2:0]  i_write_addr, i_ex_src1, i_ex_src2;
  logic        o_rf_write_en, o_data1_forward, o_data2_forward, o_port_valid, o_stall_req;
  logic [2:0]  o_rf_write_addr;
  logic [15:0] o_rf_write_data, o_data_wb, o_port_data, o_retired;

  int n_chk = 0;
  int n_pass = 0;

  wb_stage #(.DATA_W(16), .ADDR_W(3), .OUT_FIFO_DEPTH(2), .RETIRE_W(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
    .i_ex_result(i_ex_result), .i_memory_data(i_memory_data), .i_immediate(i_immediate),
    .i_in_port(i_in_port), .i_wb_selector(i_wb_selector), .i_write_back(i_write_back),
    .i_write_addr(i_write_addr), .i_output_port(i_output_port), .i_out_data(i_out_data),
    .i_ex_src1(i_ex_src1), .i_ex_src2(i_ex_src2), .i_port_ready(i_port_ready),
    .o_rf_write_en(o_rf_write_en), .o_rf_write_addr(o_rf_write_addr),
    .o_rf_write_data(o_rf_write_data), .o_data_wb(o_data_wb),
    .o_data1_forward(o_data1_forward), .o_data2_forward(o_data2_forward),
    .o_port_valid(o_port_valid), .o_port_data(o_port_data),
    .o_stall_req(o_stall_req), .o_retired(o_retired)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // advance past the next rising edge; outputs are sampled 1ns later
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic slot(input logic v, input logic fl, input logic [1:0] sel, input logic wb,
                      input logic [2:0] wa, input logic op, input logic [15:0] od);
    i_valid = v; i_flush = fl; i_wb_selector = sel; i_write_back = wb;
    i_write_addr = wa; i_output_port = op; i_out_data = od;
  endtask

  task automatic bubble();
    slot(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 16'h0);
  endtask

  logic [15:0] sel_exp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    i_reset = 1'b1; bubble();
    i_ex_result = 16'h0; i_memory_data = 16'h0; i_immediate = 16'h0; i_in_port = 16'h0;
    i_ex_src1 = 3'd4; i_ex_src2 = 3'd3; i_port_ready = 1'b0;
    #1;
    chk("reset_wen", o_rf_write_en, 0);
    chk("reset_pvalid", o_port_valid, 0);
    chk("reset_pdata", o_port_data, 0);
    chk("reset_retired", o_retired, 0);
    chk("reset_stall", o_stall_req, 0);
    #20 i_reset = 1'b0;
    tick();

    // load from memory data into r3, forwarded to src2 only
    i_memory_data = 16'hBEEF;
    slot(1'b1, 1'b0, 2'b01, 1'b1, 3'd3, 1'b0, 16'h0);
    tick();
    bubble();
    #1;
    chk("t2_wen", o_rf_write_en, 1);
    chk("t2_addr", o_rf_write_addr, 3);
    chk("t2_data", o_rf_write_data, 16'hBEEF);
    chk("t2_data_wb", o_data_wb, 16'hBEEF);
    chk("t2_fwd2", o_data2_forward, 1);
    chk("t2_fwd1", o_data1_forward, 0);
    chk("t2_retired", o_retired, 1);
    tick();
    chk("t2_bubble_wen", o_rf_write_en, 0);
    chk("t2_bubble_fwd2", o_data2_forward, 0);

    // every write-back selector, to r4 so src1 forwards
    i_ex_result = 16'h1111; i_memory_data = 16'h2222; i_immediate = 16'h3333; i_in_port = 16'h4444;
    for (int s = 0; s < 4; s++) begin
      slot(1'b1, 1'b0, 2'(s), 1'b1, 3'd4, 1'b0, 16'h0);
      tick();
      chk($sformatf("sel%0d_data", s), o_rf_write_data, sel_exp[s]);
      chk($sformatf("sel%0d_fwd1", s), o_data1_forward, 1);
    end
    bubble();
    tick();
    chk("sel_retired", o_retired, 5);

    // flush wins over a valid write-back
    slot(1'b1, 1'b1, 2'b00, 1'b1, 3'd4, 1'b0, 16'h0);
    tick();
    chk("t5_wen", o_rf_write_en, 0);
    chk("t5_fwd1", o_data1_forward, 0);
    chk("t5_retired", o_retired, 5);
    bubble();

`ifdef WB_OUT_FIFO_EN
    // fill the buffer with ready low, third OUT must stall
    slot(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1, 16'h0011);
    tick();
    chk("t3_pvalid1", o_port_valid, 1);
    chk("t3_pdata1", o_port_data, 16'h0011);
    slot(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1, 16'h0022);
    #1 chk("t3_nostall2", o_stall_req, 0);
    tick();
    slot(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1, 16'h0033);
    #1 chk("t3_stall", o_stall_req, 1);
    tick();
    chk("t3_stall_retired", o_retired, 7);
    chk("t3_stall_held", o_stall_req, 1);
    chk("t3_head_held", o_port_data, 16'h0011);
    // full buffer with ready: pop and push together, no stall
    i_port_ready = 1'b1;
    #1 chk("t4_stall", o_stall_req, 0);
    tick();
    bubble();
    #1;
    chk("t4_retired", o_retired, 8);
    chk("t4_still_full_head", o_port_data, 16'h0022);
    chk("t4_pvalid", o_port_valid, 1);
    tick();
    chk("t3_out3", o_port_data, 16'h0033);
    tick();
    chk("t3_empty", o_port_valid, 0);
    i_port_ready = 1'b0;
`else
    // single register: one-cycle pulse, no stall, ready ignored
    slot(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1, 16'h0011);
    tick();
    bubble();
    #1;
    chk("nf_pvalid", o_port_valid, 1);
    chk("nf_pdata", o_port_data, 16'h0011);
    tick();
    chk("nf_pulse_end", o_port_valid, 0);
    chk("nf_data_hold", o_port_data, 16'h0011);
    slot(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1, 16'h0022);
    #1 chk("nf_nostall", o_stall_req, 0);
    tick();
    chk("nf_pdata2", o_port_data, 16'h0022);
    slot(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1, 16'h0033);
    #1 chk("nf_nostall3", o_stall_req, 0);
    tick();
    bubble();
    #1;
    chk("nf_pdata3", o_port_data, 16'h0033);
    chk("nf_retired", o_retired, 8);
    tick();
`endif

    // reset mid-stream with two OUT words outstanding
    i_ex_result = 16'h5A5A;
    slot(1'b1, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 16'h00AA);
    tick();
    slot(1'b1, 1'b0, 2'b00, 1'b1, 3'd2, 1'b1, 16'h00BB);
    tick();
    bubble();
    chk("t1_pre_wen", o_rf_write_en, 1);
    chk("t1_pre_pvalid", o_port_valid, 1);
    chk("t1_pre_retired", o_retired, 10);
    #2 i_reset = 1'b1;
    #1;
    chk("t1_pvalid", o_port_valid, 0);
    chk("t1_retired", o_retired, 0);
    chk("t1_wen", o_rf_write_en, 0);
    chk("t1_pdata", o_port_data, 0);
    #10 i_reset = 1'b0;
    tick();

    // retire counter wrap
    slot(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 16'h0);
    for (int k = 0; k < 65535; k++) @(posedge i_clk);
    #1 chk("t6_max", o_retired, 16'hFFFF);
    tick();
    chk("t6_wrap", o_retired, 16'h0000);
    bubble();
    tick();
    chk("t6_hold", o_retired, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
